// File: rtl/traffic_scheduler_if.sv
// rtl/traffic_scheduler_if.sv - sensor/emergency inputs and light-control outputs of the scheduler
interface traffic_scheduler_if;
    logic [3:0] car_present;
    logic       emg_req;
    logic [1:0] emg_dir;
    logic [1:0] traffic_light;
    logic [1:0] phase;
    logic       emg_mode;
    logic       dir_switch;

    modport master (
        output car_present, emg_req, emg_dir,
        input  traffic_light, phase, emg_mode, dir_switch
    );

    modport slave (
        input  car_present, emg_req, emg_dir,
        output traffic_light, phase, emg_mode, dir_switch
    );
endinterface

// File: rtl/traffic_scheduler.sv
// rtl/traffic_scheduler.sv - round-robin GREEN/YELLOW/ALL_RED sequencer with emergency pre-emption
module traffic_scheduler #(
    parameter int unsigned GREEN_TIME  = 20,
    parameter int unsigned MIN_GREEN   = 5,
    parameter int unsigned YELLOW_TIME = 4,
    parameter int unsigned ALLRED_TIME = 2,
    parameter int unsigned CNT_W       = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    traffic_scheduler_if.slave   sched
);

    typedef enum logic [1:0] {
        PH_GREEN  = 2'd0,
        PH_YELLOW = 2'd1,
        PH_ALLRED = 2'd2
    } phase_e;

    localparam logic [CNT_W-1:0] GREEN_LAST  = CNT_W'(GREEN_TIME - 1);
    localparam logic [CNT_W-1:0] MIN_LAST    = CNT_W'(MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_TIME - 1);
    localparam logic [CNT_W-1:0] ALLRED_LAST = CNT_W'(ALLRED_TIME - 1);

    phase_e           phase_q, phase_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       dir_q, dir_d;
    logic             emg_mode_q, emg_mode_d;
    logic             dir_switch_q, dir_switch_d;

    logic             others_waiting;
    logic [1:0]       next_dir;

    // Next direction: first waiting car after cur, else cur; with no cars at all, rotate.
    function automatic logic [1:0] pick_next(input logic [3:0] cars, input logic [1:0] cur);
        logic [1:0] res;
        logic [1:0] idx;
        logic       found;
        res   = cur;
        found = 1'b0;
        if (cars == 4'b0000) begin
            res = cur + 2'd1;
        end else begin
            for (int k = 1; k < 4; k++) begin
                idx = cur + 2'(k);
                if (!found && cars[idx]) begin
                    res   = idx;
                    found = 1'b1;
                end
            end
        end
        return res;
    endfunction

    // Sensor view relative to the direction currently served.
    always_comb begin
        others_waiting = |(sched.car_present & ~(4'b0001 << dir_q));
        next_dir       = sched.emg_req ? sched.emg_dir : pick_next(sched.car_present, dir_q);
    end

    // Phase sequencing, emergency handling and direction selection.
    always_comb begin
        phase_d      = phase_q;
        cnt_d        = cnt_q + 1'b1;
        dir_d        = dir_q;
        emg_mode_d   = 1'b0;
        dir_switch_d = 1'b0;
        case (phase_q)
            PH_GREEN: begin
                if (sched.emg_req) begin
                    if (sched.emg_dir != dir_q) begin
                        // Pre-empt toward another direction, regardless of MIN_GREEN.
                        phase_d = PH_YELLOW;
                        cnt_d   = '0;
                    end else begin
                        // Hold GREEN on the emergency direction with the timer frozen.
                        cnt_d      = '0;
                        emg_mode_d = 1'b1;
                    end
                end else if (emg_mode_q) begin
                    // Emergency just released: leave GREEN straight away.
                    phase_d = PH_YELLOW;
                    cnt_d   = '0;
                end else if ((cnt_q == GREEN_LAST) ||
                             ((cnt_q >= MIN_LAST) && !sched.car_present[dir_q] && others_waiting)) begin
                    phase_d = PH_YELLOW;
                    cnt_d   = '0;
                end
            end
            PH_YELLOW: begin
                if (cnt_q == YELLOW_LAST) begin
                    phase_d = PH_ALLRED;
                    cnt_d   = '0;
                end
            end
            PH_ALLRED: begin
                if (cnt_q == ALLRED_LAST) begin
                    phase_d      = PH_GREEN;
                    cnt_d        = '0;
                    dir_d        = next_dir;
                    dir_switch_d = (next_dir != dir_q);
                end
            end
            default: begin
                phase_d = PH_GREEN;
                cnt_d   = '0;
            end
        endcase
    end

    // State registers; reset restarts GREEN on direction 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q      <= PH_GREEN;
            cnt_q        <= '0;
            dir_q        <= 2'd0;
            emg_mode_q   <= 1'b0;
            dir_switch_q <= 1'b0;
        end else begin
            phase_q      <= phase_d;
            cnt_q        <= cnt_d;
            dir_q        <= dir_d;
            emg_mode_q   <= emg_mode_d;
            dir_switch_q <= dir_switch_d;
        end
    end

    assign sched.traffic_light = dir_q;
    assign sched.phase         = phase_q;
    assign sched.emg_mode      = emg_mode_q;
    assign sched.dir_switch    = dir_switch_q;

endmodule

// File: tb/tb_traffic_scheduler.sv
// tb/tb_traffic_scheduler.sv - directed self-checking bench for traffic_scheduler
module tb_traffic_scheduler;

    localparam int G  = 0;
    localparam int Y  = 1;
    localparam int AR = 2;

    logic  clk;
    logic  rst;
    int    tests;
    int    fails;
    string step;

    traffic_scheduler_if sched ();

    traffic_scheduler #(
        .GREEN_TIME  (6),
        .MIN_GREEN   (3),
        .YELLOW_TIME (2),
        .ALLRED_TIME (1),
        .CNT_W       (8)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .sched (sched)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s/%s observed=%0d expected=%0d", step, tag, obs, exp);
        end
    endtask

    // Check n consecutive cycles of one phase, then advance; called at a negedge.
    task automatic run_phase(input int tl, input int ph, input int n, input int sw_first, input int emg);
        for (int i = 0; i < n; i++) begin
            chk("traffic_light", 4'(sched.traffic_light), 4'(tl));
            chk("phase", 4'(sched.phase), 4'(ph));
            chk("dir_switch", 4'(sched.dir_switch), 4'((sw_first != 0) && (i == 0)));
            chk("emg_mode", 4'(sched.emg_mode), 4'(emg));
            @(negedge clk);
        end
    endtask

    // After this returns the reset state is visible and rst is released.
    task automatic apply_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst   = 1'b1;
        sched.car_present = 4'b0000;
        sched.emg_req     = 1'b0;
        sched.emg_dir     = 2'd0;
        @(negedge clk);
        @(negedge clk);

        step = "all_cars";
        sched.car_present = 4'b1111;
        apply_reset();
        run_phase(0, G, 6, 0, 0); run_phase(0, Y, 2, 0, 0); run_phase(0, AR, 1, 0, 0);
        run_phase(1, G, 6, 1, 0); run_phase(1, Y, 2, 0, 0); run_phase(1, AR, 1, 0, 0);
        run_phase(2, G, 6, 1, 0); run_phase(2, Y, 2, 0, 0); run_phase(2, AR, 1, 0, 0);
        run_phase(3, G, 6, 1, 0); run_phase(3, Y, 2, 0, 0); run_phase(3, AR, 1, 0, 0);
        run_phase(0, G, 1, 1, 0);

        step = "early_term";
        sched.car_present = 4'b0100;
        apply_reset();
        run_phase(0, G, 3, 0, 0); run_phase(0, Y, 2, 0, 0); run_phase(0, AR, 1, 0, 0);
        run_phase(2, G, 6, 1, 0); run_phase(2, Y, 2, 0, 0); run_phase(2, AR, 1, 0, 0);
        run_phase(2, G, 1, 0, 0);

        step = "no_cars";
        sched.car_present = 4'b0000;
        apply_reset();
        run_phase(0, G, 6, 0, 0); run_phase(0, Y, 2, 0, 0); run_phase(0, AR, 1, 0, 0);
        run_phase(1, G, 6, 1, 0); run_phase(1, Y, 2, 0, 0); run_phase(1, AR, 1, 0, 0);
        run_phase(2, G, 6, 1, 0); run_phase(2, Y, 2, 0, 0); run_phase(2, AR, 1, 0, 0);
        run_phase(3, G, 6, 1, 0); run_phase(3, Y, 2, 0, 0); run_phase(3, AR, 1, 0, 0);
        run_phase(0, G, 1, 1, 0);

        step = "emg_preempt";
        sched.car_present = 4'b1111;
        apply_reset();
        run_phase(0, G, 1, 0, 0);
        sched.emg_req = 1'b1;
        sched.emg_dir = 2'd3;
        run_phase(0, G, 1, 0, 0);
        run_phase(0, Y, 2, 0, 0); run_phase(0, AR, 1, 0, 0);
        run_phase(3, G, 1, 1, 0);
        run_phase(3, G, 20, 0, 1);
        sched.emg_req = 1'b0;
        run_phase(3, G, 1, 0, 1);
        run_phase(3, Y, 2, 0, 0); run_phase(3, AR, 1, 0, 0);
        run_phase(0, G, 1, 1, 0);

        step = "emg_hold_redirect";
        apply_reset();
        run_phase(0, G, 2, 0, 0);
        sched.emg_req = 1'b1;
        sched.emg_dir = 2'd0;
        run_phase(0, G, 1, 0, 0);
        run_phase(0, G, 10, 0, 1);
        sched.emg_dir = 2'd2;
        run_phase(0, G, 1, 0, 1);
        run_phase(0, Y, 2, 0, 0); run_phase(0, AR, 1, 0, 0);
        run_phase(2, G, 1, 1, 0);
        run_phase(2, G, 3, 0, 1);
        sched.emg_req = 1'b0;
        run_phase(2, G, 1, 0, 1);
        run_phase(2, Y, 1, 0, 0);

        step = "reset_in_yellow";
        chk("traffic_light", 4'(sched.traffic_light), 4'd2);
        chk("phase", 4'(sched.phase), 4'(Y));
        apply_reset();
        run_phase(0, G, 6, 0, 0);
        run_phase(0, Y, 1, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
